// File: rtl/overdrive_ctrl_pkg.sv
// Shared types for the overdrive sequencer: opcodes, FSM encodings, command record, step helper.
package overdrive_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_EN   = 2'b00,
    OP_MAG  = 2'b01,
    OP_RATE = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAIT_EN = 2'd1;
  localparam state_t ST_RAMP    = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  localparam int unsigned RAMP_DIV_RST = 15;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
  } cmd_t;

  // One level toward tgt; callers guarantee cur != tgt, so the result stays in 0..F.
  function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt) begin
      return cur + 4'd1;
    end else if (cur > tgt) begin
      return cur - 4'd1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/overdrive_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module overdrive_cmd_fifo
  import overdrive_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  cmd_t i_wdata,
  input  logic i_pop,
  output cmd_t o_rdata,
  output logic o_full,
  output logic o_empty
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  cmd_t        r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/overdrive_ctrl.sv
// Overdrive sequencer: applies queued host commands on sample boundaries with ramped clip level.
// Define OVERDRIVE_CTRL_SOFT_BYPASS_EN to ramp the level to 0 before a disable takes effect.
module overdrive_ctrl
  import overdrive_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       od_en,
  output logic [3:0] od_magnitude,
  output logic       od_set_magnitude,
  output logic       busy,
  output logic       ramp_done,
  output logic       cmd_err
);
  logic             w_full, w_empty, w_push, w_pop, w_step;
  cmd_t             w_wcmd, w_head;
  logic             r_rdy;
  state_t           r_state, w_state_nxt;
  logic             r_en, w_en_nxt, r_en_tgt, w_en_tgt_nxt;
  logic [3:0]       r_mag, w_mag_nxt, r_tgt, w_tgt_nxt;
  logic             r_set, w_set_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt, r_cnt, w_cnt_nxt;

  assign w_wcmd.op   = op_e'(cmd_op);
  assign w_wcmd.data = cmd_data;

  // r_rdy keeps cmd_ready low during reset and for the first cycle after release.
  assign cmd_ready = r_rdy && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign w_step    = sample_tick && (r_cnt == r_div);

  assign od_en            = r_en;
  assign od_magnitude     = r_mag;
  assign od_set_magnitude = r_set;
  assign ramp_done        = r_done;
  assign cmd_err          = r_err;

  overdrive_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_wdata(w_wcmd),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_en_nxt     = r_en;
    w_en_tgt_nxt = r_en_tgt;
    w_mag_nxt    = r_mag;
    w_tgt_nxt    = r_tgt;
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_set_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pop) begin
          unique case (w_head.op)
            OP_EN: begin
              w_en_tgt_nxt = w_head.data[0];
              w_state_nxt  = ST_WAIT_EN;
`ifdef OVERDRIVE_CTRL_SOFT_BYPASS_EN
              if (!w_head.data[0] && r_en) w_state_nxt = ST_DRAIN;
`endif
            end
            OP_MAG: begin
              w_tgt_nxt   = w_head.data[3:0];
              w_state_nxt = ST_RAMP;
            end
            OP_RATE: w_div_nxt = w_head.data[DIV_W-1:0];
            OP_RSVD: w_err_nxt = 1'b1;
          endcase
        end
      end
      ST_WAIT_EN: begin
        if (sample_tick) begin
          w_en_nxt    = r_en_tgt;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (r_mag == r_tgt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_step) begin
          w_mag_nxt = step_toward(r_mag, r_tgt);
          w_set_nxt = 1'b1;
          w_cnt_nxt = '0;
        end else if (sample_tick) begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
`ifdef OVERDRIVE_CTRL_SOFT_BYPASS_EN
      ST_DRAIN: begin
        // Once silent, the disable lands on the next sample boundary.
        if (r_mag == 4'd0) begin
          if (sample_tick) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_step) begin
          w_mag_nxt = step_toward(r_mag, 4'd0);
          w_set_nxt = 1'b1;
          w_cnt_nxt = '0;
        end else if (sample_tick) begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy    <= 1'b0;
      r_state  <= ST_IDLE;
      r_en     <= 1'b0;
      r_en_tgt <= 1'b0;
      r_mag    <= 4'd0;
      r_tgt    <= 4'd0;
      r_div    <= DIV_W'(RAMP_DIV_RST);
      r_cnt    <= '0;
      r_set    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdy    <= 1'b1;
      r_state  <= w_state_nxt;
      r_en     <= w_en_nxt;
      r_en_tgt <= w_en_tgt_nxt;
      r_mag    <= w_mag_nxt;
      r_tgt    <= w_tgt_nxt;
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_set    <= w_set_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_overdrive_ctrl.sv
// Self-checking bench for overdrive_ctrl: event scoreboard plus per-scenario timing checks.
module tb_overdrive_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sample_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, od_en, od_set_magnitude, busy, ramp_done, cmd_err;
  logic [3:0] od_magnitude;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tick = -100;

  // kind: 0 = magnitude strobe (val = level), 1 = ramp_done, 2 = cmd_err
  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];
  int  strobe_cyc[$];
  int  done_cyc[$];

  bit tick_en = 1'b0;
  int tick_period = 10;
  int tick_ctr = 0;

  overdrive_ctrl #(
    .FIFO_DEPTH(4),
    .DIV_W     (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_tick     (sample_tick),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_data        (cmd_data),
    .od_en           (od_en),
    .od_magnitude    (od_magnitude),
    .od_set_magnitude(od_set_magnitude),
    .busy            (busy),
    .ramp_done       (ramp_done),
    .cmd_err         (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_tick) last_tick = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    if (tick_en) begin
      if (tick_ctr >= tick_period - 1) begin
        sample_tick = 1'b1;
        tick_ctr = 0;
      end else begin
        sample_tick = 1'b0;
        tick_ctr++;
      end
    end
  end

  // Scoreboard: every observed pulse must match the next expected event in order.
  always @(negedge clk) begin
    ev_t e;
    logic [2:0] evs;
    evs = {cmd_err, ramp_done, od_set_magnitude};
    for (int k = 0; k < 3; k++) begin
      if (evs[k] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got kind=%0d level=%0d want no event", k, od_magnitude);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || (k == 0 && e.val != int'(od_magnitude))) begin
            failures++;
            $display("FAIL sb_event got kind=%0d level=%0d want kind=%0d level=%0d",
                     k, od_magnitude, e.kind, e.val);
          end
        end
      end
    end
    if (od_set_magnitude === 1'b1) begin
      strobe_cyc.push_back(cyc);
      checks++;
      if (cyc != last_tick + 1) begin
        failures++;
        $display("FAIL strobe_timing got cycle=%0d want cycle=%0d", cyc, last_tick + 1);
      end
    end
    if (ramp_done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic exp_push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    tick_en = 1'b0;
    sample_tick = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    strobe_cyc.delete();
    done_cyc.delete();
    tick_ctr = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got cmd_ready=%b want 1 within 500 cycles", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget);
    ok = (busy === 1'b0) && (exp_q.size() == 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (od_en !== 1'b0) begin failures++; $display("FAIL rst_od_en got=%b want=0", od_en); end
    checks++;
    if (od_magnitude !== 4'h0) begin
      failures++; $display("FAIL rst_mag got=%h want=0", od_magnitude);
    end
    checks++;
    if ({od_set_magnitude, ramp_done, cmd_err} !== 3'b000) begin
      failures++;
      $display("FAIL rst_pulses got=%b want=000", {od_set_magnitude, ramp_done, cmd_err});
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rel_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_ramp_rate0();
    bit ok;
    do_reset();
    tick_period = 10;
    tick_en = 1'b1;
    push_cmd(2'b10, 8'd0);
    for (int v = 1; v <= 3; v++) exp_push(0, v);
    exp_push(1, 0);
    push_cmd(2'b01, 8'd3);
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL r0_idle got=busy want=idle"); end
    checks++;
    if (strobe_cyc.size() != 3 || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL r0_counts got strobes=%0d dones=%0d want 3 1", strobe_cyc.size(),
               done_cyc.size());
    end else begin
      checks++;
      if (strobe_cyc[1] - strobe_cyc[0] != 10 || strobe_cyc[2] - strobe_cyc[1] != 10) begin
        failures++;
        $display("FAIL r0_spacing got %0d %0d want 10 10", strobe_cyc[1] - strobe_cyc[0],
                 strobe_cyc[2] - strobe_cyc[1]);
      end
      checks++;
      if (done_cyc[0] != strobe_cyc[2] + 1) begin
        failures++;
        $display("FAIL r0_done_time got=%0d want=%0d", done_cyc[0], strobe_cyc[2] + 1);
      end
    end
    checks++;
    if (od_magnitude !== 4'd3) begin
      failures++; $display("FAIL r0_level got=%0d want=3", od_magnitude);
    end
  endtask

  task automatic test_ramp_rate2();
    bit ok;
    do_reset();
    tick_period = 10;
    tick_en = 1'b1;
    push_cmd(2'b10, 8'd2);
    exp_push(0, 1); exp_push(0, 2); exp_push(1, 0);
    exp_push(0, 1); exp_push(0, 0); exp_push(1, 0);
    push_cmd(2'b01, 8'd2);
    push_cmd(2'b01, 8'd0);
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL r2_idle got=busy want=idle"); end
    checks++;
    if (strobe_cyc.size() != 4 || done_cyc.size() != 2) begin
      failures++;
      $display("FAIL r2_counts got strobes=%0d dones=%0d want 4 2", strobe_cyc.size(),
               done_cyc.size());
    end else begin
      checks++;
      if (strobe_cyc[1] - strobe_cyc[0] != 30 || strobe_cyc[3] - strobe_cyc[2] != 30) begin
        failures++;
        $display("FAIL r2_spacing got %0d %0d want 30 30", strobe_cyc[1] - strobe_cyc[0],
                 strobe_cyc[3] - strobe_cyc[2]);
      end
    end
  endtask

  task automatic test_default_rate();
    bit ok;
    do_reset();
    exp_push(0, 1);
    exp_push(1, 0);
    push_cmd(2'b01, 8'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      if (i == 14) begin
        checks++;
        if (od_magnitude !== 4'd0) begin
          failures++; $display("FAIL div15_early got=%0d want=0 after 15 ticks", od_magnitude);
        end
      end
      if (i == 15) begin
        checks++;
        if (od_magnitude !== 4'd1) begin
          failures++; $display("FAIL div15_step got=%0d want=1 after 16 ticks", od_magnitude);
        end
      end
      @(negedge clk);
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL div15_idle got=busy want=idle"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    push_cmd(2'b00, 8'd1);
    repeat (2) @(negedge clk);
    exp_push(2, 0); exp_push(1, 0); exp_push(1, 0); exp_push(2, 0); exp_push(1, 0);
    push_cmd(2'b11, 8'd0);
    push_cmd(2'b01, 8'd0);
    push_cmd(2'b01, 8'd0);
    push_cmd(2'b11, 8'd0);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_full got cmd_ready=%b want=0", cmd_ready);
    end
    cmd_op = 2'b01;
    cmd_data = 8'd0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || exp_q.size() != 5 || od_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold got ready=%b busy=%b pending=%0d en=%b want 0 1 5 0",
               cmd_ready, busy, exp_q.size(), od_en);
    end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    push_cmd(2'b01, 8'd0);
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_idle got=busy want=idle"); end
    checks++; if (od_en !== 1'b1) begin failures++; $display("FAIL b2b_en got=%b want=1", od_en); end
  endtask

  task automatic test_en();
    do_reset();
    push_cmd(2'b00, 8'd1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_busy got=%b want=1", busy); end
    @(negedge clk);
    checks++;
    if (od_en !== 1'b0) begin failures++; $display("FAIL en_early got=%b want=0", od_en); end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    checks++;
    if (od_en !== 1'b1) begin failures++; $display("FAIL en_rise got=%b want=1", od_en); end
  endtask

  task automatic test_soft_bypass();
    bit ok;
    int n;
    do_reset();
    tick_period = 3;
    tick_en = 1'b1;
    push_cmd(2'b00, 8'd1);
    push_cmd(2'b10, 8'd0);
    for (int v = 1; v <= 15; v++) exp_push(0, v);
    exp_push(1, 0);
    push_cmd(2'b01, 8'hFF);
    wait_idle(2000, ok);
    checks++;
    if (!ok || od_en !== 1'b1 || od_magnitude !== 4'hF) begin
      failures++;
      $display("FAIL byp_setup got en=%b mag=%h want en=1 mag=F idle", od_en, od_magnitude);
    end
`ifdef OVERDRIVE_CTRL_SOFT_BYPASS_EN
    for (int v = 14; v >= 0; v--) exp_push(0, v);
    push_cmd(2'b00, 8'd0);
    n = 0;
    while (od_en !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (od_en !== 1'b0 || strobe_cyc.size() != 30 ||
        cyc != strobe_cyc[strobe_cyc.size() - 1] + 3) begin
      failures++;
      $display("FAIL drain_fall got en=%b strobes=%0d cycle=%0d want 0 30 last_strobe+3",
               od_en, strobe_cyc.size(), cyc);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || od_magnitude !== 4'd0) begin
      failures++; $display("FAIL drain_end got mag=%0d want=0 idle", od_magnitude);
    end
`else
    tick_en = 1'b0;
    sample_tick = 1'b0;
    push_cmd(2'b00, 8'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (od_en !== 1'b1 || od_magnitude !== 4'hF) begin
      failures++;
      $display("FAIL dis_wait got en=%b mag=%h want en=1 mag=F", od_en, od_magnitude);
    end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    checks++;
    if (od_en !== 1'b0 || od_magnitude !== 4'hF) begin
      failures++;
      $display("FAIL dis_fall got en=%b mag=%h want en=0 mag=F", od_en, od_magnitude);
    end
`endif
    tick_en = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic test_rsvd();
    bit ok;
    do_reset();
    push_cmd(2'b00, 8'd1);
    repeat (2) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    exp_push(2, 0);
    push_cmd(2'b11, 8'h5A);
    wait_idle(50, ok);
    checks++;
    if (!ok || od_en !== 1'b1 || od_magnitude !== 4'd0) begin
      failures++;
      $display("FAIL rsvd got en=%b mag=%0d busy=%b want en=1 mag=0 busy=0",
               od_en, od_magnitude, busy);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    do_reset();
    tick_period = 4;
    tick_en = 1'b1;
    push_cmd(2'b00, 8'd1);
    push_cmd(2'b10, 8'd0);
    for (int v = 1; v <= 9; v++) exp_push(0, v);
    exp_push(1, 0);
    push_cmd(2'b01, 8'd9);
    push_cmd(2'b01, 8'd1);
    n = 0;
    while (od_magnitude !== 4'd5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({od_en, od_magnitude, od_set_magnitude, ramp_done, cmd_err, busy, cmd_ready} !==
        10'b0) begin
      failures++;
      $display("FAIL mid_rst got en=%b mag=%h set=%b done=%b err=%b busy=%b ready=%b want all 0",
               od_en, od_magnitude, od_set_magnitude, ramp_done, cmd_err, busy, cmd_ready);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_rel got busy=%b ready=%b want 0 1", busy, cmd_ready);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (od_magnitude !== 4'd0 || od_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_flush got mag=%0d en=%b busy=%b want 0 0 0", od_magnitude, od_en, busy);
    end
    tick_en = 1'b0;
    sample_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_rate0();
    test_ramp_rate2();
    test_default_rate();
    test_back_to_back();
    test_en();
    test_soft_bypass();
    test_rsvd();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
